// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file read arbiter.
package rf_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  // Output stage occupancy: EMPTY means no response is held.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux32.sv
// 32-way word selector over a flattened register bank.
module mux32 (
  input  logic [32*32-1:0] din,
  input  logic [4:0]       sel,
  output logic [31:0]      dout
);

  // Word sel occupies bits [32*sel +: 32]; {sel, 5'b0} is sel*32.
  assign dout = din[{sel, 5'b0} +: 32];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans requesters starting at ptr, grants the first valid one.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Priority scan from ptr upward with wrap-around; the result is one-hot or zero.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// 32x32 register file with one write port and a round-robin shared read port.
// Handshake: a side transfers on a rising edge where its valid and ready are both
// 1; valid/payload hold until that edge; ready may depend on valid, never the reverse.
module rf_read_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_ena,
  input  logic [4:0]             wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [5*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [1:0]             rsp_id,
  output logic                   dbg_state
);

  logic [WIDTH-1:0]            regs [REG_COUNT];
  logic [REG_COUNT*WIDTH-1:0]  regs_flat;
  logic [1:0]                  ptr;
  logic [NUM_REQ-1:0]          grant;
  logic [1:0]                  gid;
  logic [ADDR_W-1:0]           rd_addr;
  logic [WIDTH-1:0]            mux_data;
  logic [WIDTH-1:0]            rd_data;
  logic                        can_accept;
  logic                        transfer;
  out_state_t                  state;

  // Register bank; entry 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_ena && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Flatten the bank for the word selector.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < REG_COUNT; i++) regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Accept when the output slot is free or being drained this cycle; never in reset.
  assign can_accept = rst_n && ((state == EMPTY) || rsp_ready);
  assign req_ready  = grant & {NUM_REQ{can_accept}};
  assign transfer   = |(req_valid & req_ready);

  // Encode the one-hot grant into the winning requester index.
  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gid = 2'(i);
    end
  end

  assign rd_addr = req_addr[int'(gid)*5 +: 5];

  mux32 u_mux (
    .din  (regs_flat),
    .sel  (rd_addr),
    .dout (mux_data)
  );

  // Zero for x0, otherwise forward a same-cycle write so the response sees new data.
  always_comb begin
    rd_data = mux_data;
    if (rd_addr == '0) begin
      rd_data = '0;
    end else if (wr_ena && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

  // Priority pointer moves to the requester after the winner, only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (int'(gid) == NUM_REQ - 1) ? 2'd0 : gid + 2'd1;
    end
  end

  // Output stage: captures read data on transfer and holds it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (transfer) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= rd_data;
            rsp_id    <= gid;
          end
        end
        FULL: begin
          if (rsp_ready) begin
            if (transfer) begin
              rsp_data <= rd_data;
              rsp_id   <= gid;
            end else begin
              state     <= EMPTY;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Randomized scoreboard bench for rf_read_arbiter with a behavioural model.
module tb_rf_read_arbiter;
  import rf_pkg::*;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_ena;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            dbg_state;

  // Model state: register contents, round-robin start, slot occupancy.
  logic [31:0] m_mem [32];
  int          m_ptr;
  bit          m_full;
  logic [33:0] exp_q [$];

  int tests = 0;
  int fails = 0;

  rf_read_arbiter #(.WIDTH(32), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_ptr  = 0;
    m_full = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model predicts ready, grant and the response.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [N-1:0] rv, input logic [4:0] a0, input logic [4:0] a1,
                       input logic rr);
    int          g;
    logic [N-1:0] exp_ready;
    logic [4:0]  addr;
    logic [31:0] data;
    @(negedge clk);
    wr_ena    = we;
    wr_addr   = wa;
    wr_data   = wd;
    req_valid = rv;
    req_addr  = {a1, a0};
    rsp_ready = rr;
    #2;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
    check("dbg_state", {63'd0, dbg_state}, {63'd0, m_full});
    g = -1;
    if (!m_full || rr) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      addr = (g == 0) ? a0 : a1;
      if (addr == 5'd0) data = '0;
      else if (we && wa == addr) data = wd;
      else data = m_mem[addr];
      exp_q.push_back({2'(g), data});
      m_ptr  = (g + 1) % N;
      m_full = 1;
    end else if (rr) begin
      m_full = 0;
    end
    if (we && wa != 5'd0) m_mem[wa] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    req_valid = '0;
    wr_ena    = 1'b0;
    rst_n     = 1'b1;
  endtask

  // Monitor: compare the presented response against the oldest expectation.
  always @(negedge clk) begin
    #3;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_spurious: got id %0d data %0h expected no response", rsp_id, rsp_data);
      end else begin
        check("rsp_data", 64'(rsp_data), 64'(exp_q[0][31:0]));
        check("rsp_id", 64'(rsp_id), 64'(exp_q[0][33:32]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    wr_ena    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    model_reset();
    #1;
    check("init_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("init_rsp_id", 64'(rsp_id), 64'd0);
    check("init_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read x5
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    // Writes to x0 are dropped
    cycle(1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b1);
    // Same-cycle write/read forwarding
    cycle(1'b1, 5'd7, 32'h1, 2'b00, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 2'b01, 5'd7, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    // Both requesters streaming
    repeat (6) cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b1);
    // Backpressure with a write to the held address
    cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b1);
    cycle(1'b1, 5'd5, 32'h0BADF00D, 2'b11, 5'd5, 5'd7, 1'b0);
    cycle(1'b1, 5'd7, 32'h0C0FFEE0, 2'b11, 5'd5, 5'd7, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    // Reset while FULL
    cycle(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);

    // Random traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
      if (n == 200) do_reset();
    end

    repeat (3) cycle(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
    #5;
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
